// File: rtl/interlock_out_sched_if.sv
// Bus bundle for the interlock output scheduler: raw requests, route-table
// configuration port and the granted output field.
interface interlock_out_sched_if;
    logic [1:8]  req;
    logic        cfg_we;
    logic [2:0]  cfg_ch;
    logic [1:28] cfg_mask;
    logic        cfg_err;
    logic [1:8]  grant;
    logic [1:28] eout;
    logic [3:0]  owner;
    logic        busy;

    modport master (
        output req, cfg_we, cfg_ch, cfg_mask,
        input  cfg_err, grant, eout, owner, busy
    );

    modport slave (
        input  req, cfg_we, cfg_ch, cfg_mask,
        output cfg_err, grant, eout, owner, busy
    );
endinterface

// File: rtl/interlock_out_sched.sv
// Round-robin arbiter for 8 interlock channels sharing a 28-bit output field,
// with request debounce, per-channel route masks and an enforced all-off dead-time.
module interlock_out_sched #(
    parameter int unsigned DEB_CYCLES  = 500000,
    parameter int unsigned DEAD_CYCLES = 50000
) (
    input  logic                  pclk_50M,
    input  logic                  rst,
    interlock_out_sched_if.slave  bus
);
    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DEAD} state_t;

    state_t            state, state_n;
    logic [1:8]        req_s1, req_s2, req_f;
    logic [DEB_W-1:0]  deb_cnt [1:8];
    logic [DEAD_W-1:0] dead_cnt;
    logic [3:0]        last, owner_q, sel, wr_ch;
    logic [1:28]       route_tbl [1:8];
    logic [1:28]       eout_q;
    logic [1:8]        grant_v;
    logic              cfg_err_q, wr_blocked;

    // First set request strictly after 'from', wrapping 8 -> 1; 0 when none.
    function automatic logic [3:0] rr_pick(input logic [1:8] r, input logic [3:0] from);
        logic [3:0] ch;
        logic [3:0] pick;
        pick = 4'd0;
        ch   = from;
        for (int i = 0; i < 8; i++) begin
            ch = (ch == 4'd8) ? 4'd1 : ch + 4'd1;
            if (pick == 4'd0 && r[ch]) pick = ch;
        end
        return pick;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk_50M) begin
        if (rst) begin
            req_s1 <= '0;
            req_s2 <= '0;
            req_f  <= '0;
            for (int n = 1; n <= 8; n++) deb_cnt[n] <= '0;
        end else begin
            req_s1 <= bus.req;
            req_s2 <= req_s1;
            for (int n = 1; n <= 8; n++) begin
                if (req_s2[n] == req_f[n]) begin
                    deb_cnt[n] <= '0;
                end else if (deb_cnt[n] == DEB_LAST) begin
                    req_f[n]   <= ~req_f[n];
                    deb_cnt[n] <= '0;
                end else begin
                    deb_cnt[n] <= deb_cnt[n] + DEB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge pclk_50M) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        sel     = rr_pick(req_f, last);
        case (state)
            S_IDLE:  if (sel != 4'd0)          state_n = S_GRANT;
            S_GRANT: if (!req_f[owner_q])      state_n = S_DEAD;
            S_DEAD:  if (dead_cnt == DEAD_LAST) state_n = S_IDLE;
            default:                           state_n = S_IDLE;
        endcase
    end

    // Writes to the live owner are refused so eout can never change mid-grant.
    assign wr_ch      = {1'b0, bus.cfg_ch} + 4'd1;
    assign wr_blocked = (state == S_GRANT) && (wr_ch == owner_q);

    // NOTE: the route table is reset explicitly, which forces it into flops rather than RAM.
    always_ff @(posedge pclk_50M) begin
        if (rst) begin
            last      <= 4'd8;
            owner_q   <= 4'd0;
            eout_q    <= '0;
            dead_cnt  <= '0;
            cfg_err_q <= 1'b0;
            for (int n = 1; n <= 8; n++) route_tbl[n] <= '0;
        end else begin
            case (state)
                S_IDLE: if (state_n == S_GRANT) begin
                    owner_q <= sel;
                    last    <= sel;
                    eout_q  <= route_tbl[sel];
                end
                S_GRANT: if (state_n == S_DEAD) begin
                    owner_q  <= 4'd0;
                    eout_q   <= '0;
                    dead_cnt <= '0;
                end
                S_DEAD:  dead_cnt <= dead_cnt + DEAD_W'(1);
                default: ;
            endcase

            cfg_err_q <= 1'b0;
            if (bus.cfg_we) begin
                if (wr_blocked) cfg_err_q        <= 1'b1;
                else            route_tbl[wr_ch] <= bus.cfg_mask;
            end
        end
    end

    always_comb begin
        grant_v = '0;
        if (owner_q != 4'd0) grant_v[owner_q] = 1'b1;
    end

    assign bus.grant   = grant_v;
    assign bus.eout    = eout_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = (state != S_IDLE);
    assign bus.cfg_err = cfg_err_q;
endmodule

// File: tb/tb_interlock_out_sched.sv
// Self-checking bench: directed scenarios plus random requests/config writes,
// all compared every cycle against a behavioural model of the scheduler.
module tb_interlock_out_sched;
    localparam int DEB  = 4;
    localparam int DEAD = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    interlock_out_sched_if bus();

    interlock_out_sched #(.DEB_CYCLES(DEB), .DEAD_CYCLES(DEAD)) dut (
        .pclk_50M (clk),
        .rst      (rst),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Behavioural model: two-cycle input delay, run-length debounce, owner/dead-time bookkeeping.
    bit [1:8]    m_pipe[$];
    bit [1:8]    m_reqf;
    int          m_run [1:8];
    logic [1:28] m_tbl [1:8];
    logic [1:28] m_eout;
    int          m_owner, m_last, m_dead;
    bit          m_err, m_valid = 1'b0;

    always @(posedge clk) begin
        bit [1:8] d;
        bit       blocked;
        int       pick, c, wch;
        if (rst) begin
            m_pipe.delete();
            m_pipe.push_back('0);
            m_pipe.push_back('0);
            m_reqf  = '0;
            m_eout  = '0;
            m_owner = 0;
            m_last  = 8;
            m_dead  = 0;
            m_err   = 1'b0;
            for (int n = 1; n <= 8; n++) begin
                m_run[n] = 0;
                m_tbl[n] = '0;
            end
            m_valid = 1'b1;
        end else if (m_valid) begin
            d = m_pipe.pop_front();
            m_pipe.push_back(bus.req);
            wch     = int'(bus.cfg_ch) + 1;
            blocked = bus.cfg_we && (m_owner == wch);
            m_err   = blocked;
            if (m_owner != 0) begin
                if (!m_reqf[m_owner]) begin
                    m_owner = 0;
                    m_eout  = '0;
                    m_dead  = DEAD;
                end
            end else if (m_dead > 0) begin
                m_dead--;
            end else begin
                pick = 0;
                for (int i = 1; i <= 8; i++) begin
                    c = (m_last - 1 + i) % 8 + 1;
                    if (pick == 0 && m_reqf[c]) pick = c;
                end
                if (pick != 0) begin
                    m_owner = pick;
                    m_last  = pick;
                    m_eout  = m_tbl[pick];
                end
            end
            if (bus.cfg_we && !blocked) m_tbl[wch] = bus.cfg_mask;
            for (int n = 1; n <= 8; n++) begin
                if (d[n] != m_reqf[n]) begin
                    m_run[n]++;
                    if (m_run[n] == DEB) begin
                        m_reqf[n] = ~m_reqf[n];
                        m_run[n]  = 0;
                    end
                end else begin
                    m_run[n] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [1:8] eg;
        if (m_valid) begin
            eg = '0;
            if (m_owner != 0) eg[m_owner] = 1'b1;
            check("m_grant",   bus.grant,   eg);
            check("m_eout",    bus.eout,    m_eout);
            check("m_owner",   bus.owner,   m_owner);
            check("m_busy",    bus.busy,    (m_owner != 0) || (m_dead > 0));
            check("m_cfg_err", bus.cfg_err, m_err);
            check("onehot",    $countones(bus.grant) <= 1, 1);
            check("eout_only_in_grant", (bus.eout == '0) || (bus.grant != '0), 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [1:28] mask);
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = ch;
        bus.cfg_mask = mask;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic wait_owner(input bit want_nz, output bit ok);
        int n;
        n = 0;
        while (((bus.owner != 4'd0) != want_nz) && n < 60) begin
            tick();
            n++;
        end
        ok = ((bus.owner != 4'd0) == want_nz);
    endtask

    int exp_ord [4] = '{1, 2, 8, 1};

    initial begin
        bit ok;
        int dead_n, c;
        bus.req = '0; bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_mask = '0;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_grant", bus.grant, 0);
        check("rst_eout",  bus.eout,  0);
        check("rst_owner", bus.owner, 0);
        check("rst_busy",  bus.busy,  0);
        rst = 1'b0;

        // Load, then first grant latency.
        cfg_write(3'd0, 28'hF000000);
        check("cfg_ok_ch1", bus.cfg_err, 0);
        cfg_write(3'd2, 28'h0000068);
        bus.req[3] = 1'b1;
        repeat (6) tick();
        check("lat_before", bus.grant, 0);
        tick();
        check("lat_grant", bus.grant, 8'b00100000);
        check("lat_owner", bus.owner, 3);
        check("lat_eout",  bus.eout,  28'h0000068);
        check("lat_busy",  bus.busy,  1);

        // Short glitch on channel 5.
        bus.req[5] = 1'b1;
        repeat (3) tick();
        bus.req[5] = 1'b0;
        repeat (8) tick();
        check("glitch_reqf5", dut.req_f[5], 0);
        check("glitch_owner", bus.owner, 3);
        check("glitch_eout",  bus.eout, 28'h0000068);

        // Config protection.
        bus.cfg_we = 1'b1; bus.cfg_ch = 3'd2; bus.cfg_mask = 28'h1;
        tick();
        bus.cfg_we = 1'b0;
        check("prot_err",  bus.cfg_err, 1);
        check("prot_eout", bus.eout, 28'h0000068);
        tick();
        check("prot_err_pulse", bus.cfg_err, 0);
        cfg_write(3'd0, 28'hF000000);
        check("nonowner_ok", bus.cfg_err, 0);
        check("nonowner_eout", bus.eout, 28'h0000068);

        // Handover 3 -> 1 through dead-time.
        bus.req[1] = 1'b1;
        repeat (8) tick();
        check("no_preempt", bus.owner, 3);
        bus.req[3] = 1'b0;
        wait_owner(1'b0, ok);
        check("release_wait", ok, 1);
        check("release_eout", bus.eout, 0);
        dead_n = 0;
        while (bus.busy && bus.owner == 4'd0 && dead_n < 20) begin
            dead_n++;
            tick();
        end
        check("dead_len", dead_n, DEAD);
        wait_owner(1'b1, ok);
        check("handover_wait",  ok, 1);
        check("handover_grant", bus.grant, 8'b10000000);
        check("handover_eout",  bus.eout, 28'hF000000);

        // Fairness from reset with zero masks.
        bus.req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 8'b11000001;
        for (int i = 0; i < 4; i++) begin
            wait_owner(1'b1, ok);
            check("fair_wait",  ok, 1);
            check("fair_order", bus.owner, exp_ord[i]);
            check("fair_zero_mask", bus.eout, 0);
            if (i < 3) begin
                c = int'(bus.owner);
                bus.req[c] = 1'b0;
                wait_owner(1'b0, ok);
                check("fair_release", ok, 1);
                bus.req[c] = 1'b1;
            end
        end

        // Reset mid-grant, then reload and re-grant.
        bus.req = 8'b10000000;
        rst = 1'b1;
        tick();
        check("mid_rst_grant", bus.grant, 0);
        check("mid_rst_eout",  bus.eout,  0);
        check("mid_rst_owner", bus.owner, 0);
        check("mid_rst_busy",  bus.busy,  0);
        rst = 1'b0;
        cfg_write(3'd0, 28'hF000000);
        repeat (5) tick();
        check("regrant_before", bus.grant, 0);
        tick();
        check("regrant_grant", bus.grant, 8'b10000000);
        check("regrant_eout",  bus.eout,  28'hF000000);

        // Random traffic against the model.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int n = 1; n <= 8; n++)
                if ($urandom_range(15) == 0) bus.req[n] = ~bus.req[n];
            bus.cfg_we   = ($urandom_range(7) == 0);
            bus.cfg_ch   = 3'($urandom_range(7));
            bus.cfg_mask = 28'($urandom);
            rst          = ($urandom_range(499) == 0);
            tick();
        end
        bus.cfg_we = 1'b0;
        rst = 1'b0;
        bus.req = '0;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
